// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter sharing one slave: fair tie-break on the last
// owner, ownership held for the whole cycle, and a stall timeout that errors the owner.
module wb_arbiter2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  input  logic [ADDR_WIDTH-1:0]   m0_adr,
  input  logic [DATA_WIDTH-1:0]   m0_wdat,
  output logic [DATA_WIDTH-1:0]   m0_rdat,
  output logic                    m0_ack,
  output logic                    m0_err,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  input  logic [ADDR_WIDTH-1:0]   m1_adr,
  input  logic [DATA_WIDTH-1:0]   m1_wdat,
  output logic [DATA_WIDTH-1:0]   m1_rdat,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [DATA_WIDTH/8-1:0] s_sel,
  output logic [ADDR_WIDTH-1:0]   s_adr,
  output logic [DATA_WIDTH-1:0]   s_wdat,
  input  logic [DATA_WIDTH-1:0]   s_rdat,
  input  logic                    s_ack,
  input  logic                    s_err,
  output logic [1:0]              grant
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  // Counter value on the stall cycle that must raise the timeout error.
  localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] stall_q, stall_d;
  logic       own_stb, stall, timeout;

  assign own_stb = ((state_q == OWN0) && m0_stb) || ((state_q == OWN1) && m1_stb);
  assign stall   = own_stb && !s_ack && !s_err;
  assign timeout = stall && (stall_q == STALL_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      stall_q <= stall_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    stall_d = '0;
    case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_d = last_q ? OWN0 : OWN1;
        else if (m0_cyc)      state_d = OWN0;
        else if (m1_cyc)      state_d = OWN1;
      end
      OWN0: begin
        if (!m0_cyc) begin
          last_d  = 1'b0;
          state_d = m1_cyc ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_cyc) begin
          last_d  = 1'b1;
          state_d = m0_cyc ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Any ack, err, idle strobe, timeout or ownership change restarts the count.
    if ((state_d == state_q) && stall && !timeout) stall_d = stall_q + 8'd1;
  end

  always_comb begin
    s_cyc  = 1'b0;
    s_stb  = 1'b0;
    s_we   = 1'b0;
    s_sel  = '0;
    s_adr  = '0;
    s_wdat = '0;
    m0_ack = 1'b0;
    m0_err = 1'b0;
    m1_ack = 1'b0;
    m1_err = 1'b0;
    grant  = 2'b00;
    case (state_q)
      OWN0: begin
        grant  = 2'b01;
        s_cyc  = m0_cyc && !timeout;
        s_stb  = m0_stb && !timeout;
        s_we   = m0_we;
        s_sel  = m0_sel;
        s_adr  = m0_adr;
        s_wdat = m0_wdat;
        m0_ack = s_ack && !s_err && !timeout;
        m0_err = s_err || timeout;
      end
      OWN1: begin
        grant  = 2'b10;
        s_cyc  = m1_cyc && !timeout;
        s_stb  = m1_stb && !timeout;
        s_we   = m1_we;
        s_sel  = m1_sel;
        s_adr  = m1_adr;
        s_wdat = m1_wdat;
        m1_ack = s_ack && !s_err && !timeout;
        m1_err = s_err || timeout;
      end
      default: ;
    endcase
  end

  assign m0_rdat = s_rdat;
  assign m1_rdat = s_rdat;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: tie-break, alternation, isolation,
// stall timeout, ack/err priority and asynchronous reset mid-transfer.
module tb_wb_arbiter2;

  logic        clock, reset;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic [31:0] m0_adr, m1_adr, m0_wdat, m1_wdat, m0_rdat, m1_rdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we, s_ack, s_err;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  wb_arbiter2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
    .m0_adr(m0_adr), .m0_wdat(m0_wdat), .m0_rdat(m0_rdat),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
    .m1_adr(m1_adr), .m1_wdat(m1_wdat), .m1_rdat(m1_rdat),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
    .s_adr(s_adr), .s_wdat(s_wdat), .s_rdat(s_rdat),
    .s_ack(s_ack), .s_err(s_err), .grant(grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1;
    #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b want 0", s_cyc); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL reset_m0_ack: got %b want 0", m0_ack); end
    next_cycle();
    next_cycle();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_hold_grant: got %b want 00", grant); end
    checks++; if (s_adr !== 32'h0) begin errors++; $display("FAIL reset_s_adr: got %h want 0", s_adr); end
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_tie();
    m0_cyc = 1'b1; m1_cyc = 1'b1; m0_stb = 1'b1; m1_stb = 1'b1;
    m0_adr = 32'h0000_0100; m1_adr = 32'h0000_0200;
    @(negedge clock);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_latency: got %b want 00", grant); end
    next_cycle();
    @(negedge clock);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_first: got %b want 01", grant); end
    checks++; if (s_adr !== 32'h0000_0100) begin errors++; $display("FAIL tie_s_adr0: got %h want 00000100", s_adr); end
    next_cycle();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clock);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_hold: got %b want 01", grant); end
    next_cycle();
    @(negedge clock);
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tie_handover: got %b want 10", grant); end
    checks++; if (s_adr !== 32'h0000_0200) begin errors++; $display("FAIL tie_s_adr1: got %h want 00000200", s_adr); end
    next_cycle();
    m1_cyc = 1'b0; m1_stb = 1'b0;
    next_cycle();
    @(negedge clock);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_idle: got %b want 00", grant); end
    next_cycle();
  endtask

  task automatic test_alternate();
    logic [1:0] exp_grant;
    m0_cyc = 1'b1; m1_cyc = 1'b1; m0_stb = 1'b1; m1_stb = 1'b1;
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      exp_grant = (i % 2 == 0) ? 2'b01 : 2'b10;
      s_ack = 1'b1;
      m0_cyc = 1'b1; m1_cyc = 1'b1;
      @(negedge clock);
      checks++; if (grant !== exp_grant) begin errors++; $display("FAIL alt_grant[%0d]: got %b want %b", i, grant, exp_grant); end
      checks++; if ({m1_ack, m0_ack} !== exp_grant) begin errors++; $display("FAIL alt_ack[%0d]: got %b want %b", i, {m1_ack, m0_ack}, exp_grant); end
      next_cycle();
      s_ack = 1'b0;
      if (i % 2 == 0) m0_cyc = 1'b0; else m1_cyc = 1'b0;
      @(negedge clock);
      checks++; if (grant !== exp_grant) begin errors++; $display("FAIL alt_hold[%0d]: got %b want %b", i, grant, exp_grant); end
      next_cycle();
    end
    m0_cyc = 1'b0; m1_cyc = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0;
    next_cycle();
    @(negedge clock);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL alt_idle: got %b want 00", grant); end
    next_cycle();
  endtask

  task automatic test_isolation();
    m0_cyc = 1'b1; m1_cyc = 1'b1; m0_stb = 1'b1; m1_stb = 1'b1;
    m0_adr = 32'h7000_0004; m1_adr = 32'h1234_5678;
    next_cycle();
    s_ack = 1'b1; s_rdat = 32'hCAFE_F00D;
    @(negedge clock);
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL iso_grant: got %b want 10", grant); end
    checks++; if (s_adr !== 32'h1234_5678) begin errors++; $display("FAIL iso_s_adr: got %h want 12345678", s_adr); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL iso_m0_ack: got %b want 0", m0_ack); end
    checks++; if (m1_ack !== 1'b1) begin errors++; $display("FAIL iso_m1_ack: got %b want 1", m1_ack); end
    checks++; if (m0_rdat !== 32'hCAFE_F00D || m1_rdat !== 32'hCAFE_F00D) begin errors++; $display("FAIL iso_rdat: got %h/%h want cafef00d", m0_rdat, m1_rdat); end
    m1_adr = 32'hABCD_0000; m1_we = 1'b1; m1_wdat = 32'hDEAD_BEEF; m1_sel = 4'b0110;
    m0_we = 1'b1; m0_sel = 4'b1111; m0_wdat = 32'h1111_1111;
    #1;
    checks++; if (s_adr !== 32'hABCD_0000) begin errors++; $display("FAIL iso_track_adr: got %h want abcd0000", s_adr); end
    checks++; if ({s_we, s_sel, s_wdat} !== {1'b1, 4'b0110, 32'hDEAD_BEEF}) begin errors++; $display("FAIL iso_track_wr: got %b %b %h want 1 0110 deadbeef", s_we, s_sel, s_wdat); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL iso_m0_ack2: got %b want 0", m0_ack); end
    next_cycle();
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; s_ack = 1'b0;
    next_cycle();
    @(negedge clock);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL iso_to_m0: got %b want 01", grant); end
    checks++; if (s_adr !== 32'h7000_0004) begin errors++; $display("FAIL iso_m0_adr: got %h want 70000004", s_adr); end
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  task automatic stall_run(input int n, input string tag);
    logic exp_err;
    for (int k = 1; k <= n; k++) begin
      exp_err = (k % 4 == 0);
      @(negedge clock);
      checks++; if (m0_err !== exp_err) begin errors++; $display("FAIL %s_err[%0d]: got %b want %b", tag, k, m0_err, exp_err); end
      checks++; if ({s_cyc, s_stb} !== {2{!exp_err}}) begin errors++; $display("FAIL %s_stb[%0d]: got %b%b want %b%b", tag, k, s_cyc, s_stb, !exp_err, !exp_err); end
      checks++; if (m1_err !== 1'b0 || m0_ack !== 1'b0) begin errors++; $display("FAIL %s_quiet[%0d]: got m1_err=%b m0_ack=%b want 0 0", tag, k, m1_err, m0_ack); end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    s_ack = 1'b0; s_err = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    next_cycle();
    stall_run(8, "to_held");
    next_cycle();
    next_cycle();
    m0_stb = 1'b0;
    next_cycle();
    m0_stb = 1'b1;
    stall_run(4, "to_restart");
  endtask

  task automatic test_ack_err();
    s_ack = 1'b1; s_err = 1'b1;
    @(negedge clock);
    checks++; if ({m0_err, m0_ack} !== 2'b10) begin errors++; $display("FAIL both_term: got err=%b ack=%b want err=1 ack=0", m0_err, m0_ack); end
    checks++; if ({m1_err, m1_ack} !== 2'b00) begin errors++; $display("FAIL both_nonowner: got err=%b ack=%b want 0 0", m1_err, m1_ack); end
    s_err = 1'b0;
    #1;
    checks++; if ({m0_err, m0_ack} !== 2'b01) begin errors++; $display("FAIL ack_only: got err=%b ack=%b want err=0 ack=1", m0_err, m0_ack); end
    next_cycle();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    next_cycle();
    @(negedge clock);
    checks++; if ({grant, s_cyc} !== 3'b011) begin errors++; $display("FAIL rmid_own: got grant=%b s_cyc=%b want 01 1", grant, s_cyc); end
    #2;
    s_ack = 1'b1;
    reset = 1'b1;
    #1;
    checks++; if ({s_cyc, s_stb} !== 2'b00) begin errors++; $display("FAIL rmid_s_cyc: got %b%b want 00", s_cyc, s_stb); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rmid_grant: got %b want 00", grant); end
    checks++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin errors++; $display("FAIL rmid_term: got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
    s_ack = 1'b0;
    next_cycle();
    reset = 1'b0;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    @(negedge clock);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rmid_release: got %b want 00", grant); end
    next_cycle();
    @(negedge clock);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmid_tie: got %b want 01", grant); end
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    next_cycle();
  endtask

  initial begin
    reset = 1'b1;
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = '0; m0_adr = '0; m0_wdat = '0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = '0; m1_adr = '0; m1_wdat = '0;
    s_rdat = '0; s_ack = 1'b0; s_err = 1'b0;
    test_reset();
    test_tie();
    test_alternate();
    test_isolation();
    test_timeout();
    test_ack_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, data width (multiple of 8).
REQ-003 SHALL provide parameter TIMEOUT, default 255, stall cycles before bus error; range 1 to 255.
REQ-004 SHALL provide port clock, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL provide port reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL provide ports m0_cyc/m1_cyc, input, 1, master cycle request.
REQ-007 SHALL provide ports m0_stb/m1_stb, input, 1, master strobe.
REQ-008 SHALL provide ports m0_we/m1_we, input, 1, write enable.
REQ-009 SHALL provide ports m0_sel/m1_sel, input, DATA_WIDTH/8, byte selects.
REQ-010 SHALL provide ports m0_adr/m1_adr, input, ADDR_WIDTH, address.
REQ-011 SHALL provide ports m0_wdat/m1_wdat, input, DATA_WIDTH, write data.
REQ-012 SHALL provide ports m0_rdat/m1_rdat, output, DATA_WIDTH, read data.
REQ-013 SHALL provide ports m0_ack/m1_ack and m0_err/m1_err, output, 1 each, termination.
REQ-014 SHALL provide ports s_cyc, s_stb, s_we, output, 1 each, to the shared slave.
REQ-015 SHALL provide ports s_sel, s_adr and s_wdat, output, DATA_WIDTH/8, ADDR_WIDTH and DATA_WIDTH respectively.
REQ-016 SHALL provide ports s_rdat, input, DATA_WIDTH, and s_ack and s_err, input, 1 each.
REQ-017 SHALL provide port grant, output, 2, one-hot registered owner; 2'b00 when idle.

Function
REQ-018 SHALL implement FSM states IDLE, OWN0 and OWN1, plus a 1-bit last-owner register and an 8-bit stall counter.
REQ-019 In IDLE, a single requesting master SHALL be granted; under simultaneous requests, the master not equal to last-owner SHALL win. The state changes on the next edge, giving 1-cycle arbitration latency.
REQ-020 In OWNn, s_cyc/s_stb/s_we/s_sel/s_adr/s_wdat SHALL combinationally equal master n's signals; mn_ack=s_ack, mn_err=s_err, mn_rdat=s_rdat.
REQ-021 The non-owner's ack and err SHALL be 0 at all times; all m*_rdat SHALL equal s_rdat.
REQ-022 In IDLE, all s_* outputs SHALL be 0.
REQ-023 On mn_cyc deassert in OWNn: last-owner:=n; if the other master's cyc=1, go directly to OWN(other), else IDLE. Ownership SHALL never change while the owner's cyc=1.
REQ-024 The stall counter SHALL increment each OWNn cycle with s_stb=1, s_ack=0 and s_err=0; it SHALL clear on ack, on err, on stb=0, or on a state change.
REQ-025 When the counter reaches TIMEOUT, the arbiter SHALL assert mn_err for exactly that cycle, force s_cyc=s_stb=0 that cycle, and clear the counter.
REQ-026 If s_ack and s_err are both asserted, the master SHALL see err=1 and ack=0.
REQ-027 grant SHALL reflect the registered state: 2'b01 in OWN0, 2'b10 in OWN1.

Reset
REQ-028 While reset=1, the arbiter SHALL hold state=IDLE, last-owner=1 (so m0 wins the first tie), counter=0 and grant=0; all outputs then follow REQ-022.
REQ-029 Reset mid-transaction SHALL drop s_cyc immediately (asynchronously) with no ack/err to either master.

Verification
REQ-030 Reset release, then m0_cyc=m1_cyc=1 on the same cycle -> grant=01 after 1 cycle; after m0 releases, grant=10 the next cycle.
REQ-031 Both masters continuously requesting, each holding cyc for a single transfer -> grants alternate 01,10,01,10 with no idle gap.
REQ-032 m1 owns the bus with m0_adr=0x7000_0004, m0_stb=1 -> s_adr tracks m1_adr only; m0_ack=0 throughout.
REQ-033 TIMEOUT=4 and a slave that never acks -> mn_err=1 on the 4th stalled cycle with s_stb=0 in that cycle; the counter restarts if stb is held.
REQ-034 s_ack=s_err=1 together -> the owner sees err=1, ack=0.
REQ-035 reset asserted during OWN0 with s_stb=1 -> s_cyc=0 and grant=00 before the next clock edge; after release, m0 wins a tie.
